// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply (IDLE->DONE); divide path unchanged.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// BUSY  | iterating, counter counts XLEN down to 0
// DONE  | result valid, held until out_ready or flush
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] input_a,
  input  logic [XLEN-1:0] input_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int AW = 2*XLEN + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [AW-1:0]     acc_q, acc_step, acc_mul, acc_div, div_sh;
  logic [XLEN-1:0]   mag_q;
  logic [2:0]        op_q;
  logic              neg_q;

  logic              accept;
  logic              sa_in, sb_in, a_neg, b_neg, neg_in, div_zero, ovf, bypass;
  logic [XLEN-1:0]   ma_in, mb_in, byp_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin_res;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  assign accept    = (state_q == S_IDLE) && in_valid && !flush;
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);

  // request decode: operand magnitudes, result sign, and the single-cycle special cases
  always_comb begin
    sa_in    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sb_in    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = sa_in && input_a[XLEN-1];
    b_neg    = sb_in && input_b[XLEN-1];
    ma_in    = a_neg ? -input_a : input_a;
    mb_in    = b_neg ? -input_b : input_b;
    neg_in   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = op[2] && (input_b == '0);
    ovf      = op[2] && !op[0] && (input_a == MOST_NEG) && (input_b == '1);
    if (div_zero) byp_res = op[1] ? input_a : '1;
    else          byp_res = op[1] ? '0 : input_a;
    bypass   = div_zero || ovf;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, ma_in} * {{XLEN{1'b0}}, mb_in};
    if (neg_in) fast_prod = -fast_prod;
    if (!op[2]) begin
      bypass  = 1'b1;
      byp_res = (op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // one iteration step plus sign correction of the finished value
  always_comb begin
    mul_sum  = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, mag_q} : '0);
    acc_mul  = {1'b0, mul_sum, acc_q[XLEN-1:1]};
    div_sh   = {acc_q[AW-2:0], 1'b0};
    div_diff = {1'b0, div_sh[AW-1:XLEN]} - {2'b00, mag_q};
    acc_div  = div_diff[XLEN+1] ? div_sh : {div_diff[XLEN:0], div_sh[XLEN-1:1], 1'b1};
    acc_step = op_q[2] ? acc_div : acc_mul;
    prod     = neg_q ? -acc_step[2*XLEN-1:0] : acc_step[2*XLEN-1:0];
    quo      = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem      = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fin_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = bypass ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (flush)                     state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))   state_d = S_DONE;
      end
      S_DONE: if (flush || out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      mag_q  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op;
      neg_q <= neg_in;
      cnt_q <= CNT_W'(XLEN);
      if (op[2]) begin
        acc_q <= {{(XLEN+1){1'b0}}, ma_in};
        mag_q <= mb_in;
      end else begin
        acc_q <= {{(XLEN+1){1'b0}}, mb_in};
        mag_q <= ma_in;
      end
      if (bypass) result <= byp_res;
    end else if (state_q == S_BUSY && !flush) begin
      cnt_q <= cnt_q - CNT_W'(1);
      acc_q <= acc_step;
      if (cnt_q == CNT_W'(1)) result <= fin_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32, default build).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] input_a = '0;
  logic [31:0] input_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .input_a(input_a), .input_b(input_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // accept edge counts as edge 1; inputs are scrambled after accept
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int edges;
    @(negedge clk);
    in_valid = 1'b1; op = o; input_a = a; input_b = b;
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); edges = 1; #1;
    in_valid = 1'b0; op = 3'($urandom); input_a = $urandom; input_b = $urandom;
    while (out_valid !== 1'b1 && edges < 100) begin
      @(posedge clk); edges++; #1;
    end
    check({tag, "/latency"}, 64'(edges), 64'(exp_lat));
    check({tag, "/result"}, 64'(result), 64'(exp_r));
    @(posedge clk); #1;
    check({tag, "/retire"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int saw;
    int edges;

    #1 reset_n = 1'b0;
    #1;
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/result", 64'(result), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run_op("mulh_m1x2",    3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
    run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    run_op("divu_by0",     3'b101, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1);
    run_op("remu_by0",     3'b111, 32'h00001234, 32'h00000000, 32'h00001234, 1);
    run_op("div_by0",      3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1);
    run_op("rem_by0",      3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1);
    run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("mul_basic",    3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33);
    run_op("mul_neg",      3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 33);
    run_op("mulhsu",       3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("mulhu_shift",  3'b011, 32'h80000000, 32'h00000004, 32'h00000002, 33);
    run_op("mulh_pos",     3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 33);
    run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33);

    // back-pressure: result held while out_ready=0
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b011; input_a = 32'hFFFFFFFF; input_b = 32'hFFFFFFFF;
    @(posedge clk); edges = 1; #1;
    in_valid = 1'b0; input_a = 32'h0; input_b = 32'h0;
    while (out_valid !== 1'b1 && edges < 100) begin
      @(posedge clk); edges++; #1;
    end
    check("mulhu_hold/latency", 64'(edges), 64'd33);
    saw = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (result !== 32'hFFFFFFFE || in_ready !== 1'b0 || out_valid !== 1'b1) saw++;
    end
    check("mulhu_hold/stable", 64'(saw), 64'd0);
    check("mulhu_hold/result", 64'(result), 64'hFFFFFFFE);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mulhu_hold/idle", 64'(in_ready), 64'd1);
    check("mulhu_hold/busy", 64'(busy), 64'd0);

    // flush at cycle 10 of a DIVU
    @(negedge clk);
    in_valid = 1'b1; op = 3'b101; input_a = 32'd1000; input_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("flush/busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush/busy_after", 64'(busy), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw++;
    end
    check("flush/no_valid", 64'(saw), 64'd0);

    // request coincident with flush must not be accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 3'b101; input_a = 32'd9; input_b = 32'd3;
    @(posedge clk); #1;
    check("flush_vs_accept/busy", 64'(busy), 64'd0);
    check("flush_vs_accept/out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    run_op("divu_after_flush", 3'b101, 32'd1000, 32'd3, 32'd333, 33);

    // reset pulsed low mid-BUSY
    @(negedge clk);
    in_valid = 1'b1; op = 3'b000; input_a = 32'd77; input_b = 32'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid/busy", 64'(busy), 64'd0);
    check("rst_mid/out_valid", 64'(out_valid), 64'd0);
    check("rst_mid/in_ready", 64'(in_ready), 64'd1);
    check("rst_mid/result", 64'(result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw++;
    end
    check("rst_mid/no_valid", 64'(saw), 64'd0);
    run_op("remu_after_rst", 3'b111, 32'd1000, 32'd3, 32'd1, 33);
    run_op("mul_after_rst",  3'b000, 32'd77,   32'd11, 32'd847, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
